// File: rtl/i2s_synchronizer_if.sv
// rtl/i2s_synchronizer_if.sv - I2S pin and synchronized-output bundle for the input front end
interface i2s_synchronizer_if;
    // Raw, asynchronous I2S pins
    logic _sck;
    logic _sd;
    logic _ws;

    // Signals in the system clock domain
    logic sck;
    logic sck_transition;
    logic sd;
    logic ws;

    // Pin side: drives the raw pins, observes the synchronized view
    modport master (
        output _sck,
        output _sd,
        output _ws,
        input  sck,
        input  sck_transition,
        input  sd,
        input  ws
    );

    // Synchronizer side: samples the raw pins, drives the synchronized view
    modport slave (
        input  _sck,
        input  _sd,
        input  _ws,
        output sck,
        output sck_transition,
        output sd,
        output ws
    );
endinterface

// File: rtl/i2s_synchronizer.sv
// rtl/i2s_synchronizer.sv - multi-flop CDC of I2S pins with serial-clock rising-edge strobe
module i2s_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    i2s_synchronizer_if.slave   bus
);

    // Bit 0 samples the pin, bit SYNC_STAGES-1 is the synchronized output.
    // All three chains share one length so pin-to-pin skew is preserved.
    logic [SYNC_STAGES-1:0] sck_chain;
    logic [SYNC_STAGES-1:0] sd_chain;
    logic [SYNC_STAGES-1:0] ws_chain;

    // Previous value of the synchronized serial clock for edge detection.
    logic sck_d;

    // Shift each pin through its own synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_chain <= '0;
            sd_chain  <= '0;
            ws_chain  <= '0;
        end else begin
            sck_chain <= {sck_chain[SYNC_STAGES-2:0], bus._sck};
            sd_chain  <= {sd_chain[SYNC_STAGES-2:0],  bus._sd};
            ws_chain  <= {ws_chain[SYNC_STAGES-2:0],  bus._ws};
        end
    end

    // Delay the synchronized serial clock by one cycle. Clearing it on reset
    // means a pin already high at release yields one strobe downstream skips.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_d <= 1'b0;
        end else begin
            sck_d <= sck_chain[SYNC_STAGES-1];
        end
    end

    // Outputs come straight from flops; the strobe combines two flops only,
    // so it cannot glitch and has no path from any pin.
    assign bus.sck            = sck_chain[SYNC_STAGES-1];
    assign bus.sd             = sd_chain[SYNC_STAGES-1];
    assign bus.ws             = ws_chain[SYNC_STAGES-1];
    assign bus.sck_transition = sck_chain[SYNC_STAGES-1] & ~sck_d;

endmodule

// File: tb/tb_i2s_synchronizer.sv
// tb/tb_i2s_synchronizer.sv - directed self-checking bench for i2s_synchronizer
module tb_i2s_synchronizer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    i2s_synchronizer_if bus ();

    i2s_synchronizer #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe bookkeeping, refreshed per scenario
    int         cyc       = 0;
    int         strobes   = 0;
    int         last_tr   = 0;
    int         exp_gap   = 0;
    int         bad_gap   = 0;
    int         bad_width = 0;
    int         bad_fall  = 0;
    logic       prev_tr   = 1'b0;
    logic [1:0] cap[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic reset_stats(input int gap);
        strobes   = 0;
        bad_gap   = 0;
        bad_width = 0;
        bad_fall  = 0;
        exp_gap   = gap;
        cap.delete();
    endtask

    // Drive the pins just after a rising edge, observe on the falling edge.
    task automatic step(input logic s, input logic d, input logic w);
        @(posedge clk);
        #1;
        bus._sck = s;
        bus._sd  = d;
        bus._ws  = w;
        @(negedge clk);
        cyc++;
        if (bus.sck_transition === 1'b1) begin
            cap.push_back({bus.ws, bus.sd});
            strobes++;
            if (exp_gap != 0 && strobes > 1 && (cyc - last_tr) != exp_gap) bad_gap++;
            last_tr = cyc;
            if (bus.sck !== 1'b1) bad_fall++;
            if (prev_tr === 1'b1) bad_width++;
        end
        prev_tr = bus.sck_transition;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [15:0] words[6];
        logic        sd_q[$];
        logic        ws_q[$];
        logic [15:0] w;
        logic        ch;
        logic [2:0]  p;

        bus._sck = 1'b0;
        bus._sd  = 1'b0;
        bus._ws  = 1'b0;

        // Reset held with pins toggling: everything stays low
        for (int i = 0; i < 20; i++) begin
            p = 3'(i + 3);
            step(p[0], p[1], p[2]);
            check_val("reset_hold", {28'd0, bus.sck, bus.sd, bus.ws, bus.sck_transition}, 32'h0);
        end
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        check_val("release_cycle1", {28'd0, bus.sck, bus.sd, bus.ws, bus.sck_transition}, 32'h0);
        step(1'b1, 1'b1, 1'b1);
        check_val("release_follow", {28'd0, bus.sck, bus.sd, bus.ws, bus.sck_transition}, 32'hF);
        step(1'b1, 1'b1, 1'b1);
        check_val("release_strobe_once", {31'd0, bus.sck_transition}, 32'h0);

        // Latency of each chain from a static background
        repeat (5) step(1'b0, 1'b0, 1'b0);
        check_val("lat_idle", {28'd0, bus.sck, bus.sd, bus.ws, bus.sck_transition}, 32'h0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_val("sd_lat_edge1", {31'd0, bus.sd}, 32'h0);
        step(1'b0, 1'b1, 1'b0);
        check_val("sd_lat_edge2", {31'd0, bus.sd}, 32'h1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_val("ws_lat_edge1", {31'd0, bus.ws}, 32'h0);
        step(1'b0, 1'b1, 1'b1);
        check_val("ws_lat_edge2", {31'd0, bus.ws}, 32'h1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_val("sck_lat_edge1", {30'd0, bus.sck, bus.sck_transition}, 32'h0);
        step(1'b1, 1'b1, 1'b1);
        check_val("sck_lat_edge2", {30'd0, bus.sck, bus.sck_transition}, 32'h3);
        step(1'b1, 1'b1, 1'b1);
        check_val("sck_strobe_drop", {30'd0, bus.sck, bus.sck_transition}, 32'h2);
        repeat (6) step(1'b0, 1'b0, 1'b0);

        // 100 periods of 40-cycle half-period
        reset_stats(80);
        for (int i = 0; i < 100; i++) begin
            repeat (40) step(1'b1, 1'b0, 1'b0);
            repeat (40) step(1'b0, 1'b0, 1'b0);
        end
        check_val("slow_strobe_count", strobes, 100);
        check_val("slow_strobe_spacing", bad_gap, 0);
        check_val("slow_strobe_width", bad_width, 0);
        check_val("slow_no_fall_strobe", bad_fall, 0);

        // I2S frame: leading slot announces left, ws flips one bit before each MSB
        words[0] = 16'hAAAA; words[1] = 16'hFFFF;
        words[2] = 16'h1478; words[3] = 16'hA3B9;
        words[4] = 16'h0001; words[5] = 16'hFFFF;
        sd_q.push_back(1'b0);
        ws_q.push_back(1'b0);
        for (int k = 0; k < 6; k++) begin
            ch = k[0];
            w  = words[k];
            for (int b = 15; b >= 0; b--) begin
                sd_q.push_back(w[b]);
                ws_q.push_back(b == 0 ? ~ch : ch);
            end
        end
        sd_q.push_back(1'b0);
        ws_q.push_back(1'b0);
        reset_stats(8);
        repeat (4) step(1'b0, sd_q[0], ws_q[0]);
        for (int j = 0; j < 97; j++) begin
            repeat (2) step(1'b1, sd_q[j], ws_q[j]);
            repeat (2) step(1'b1, sd_q[j+1], ws_q[j+1]);
            repeat (4) step(1'b0, sd_q[j+1], ws_q[j+1]);
        end
        repeat (6) step(1'b0, 1'b0, 1'b0);
        check_val("frame_strobe_count", strobes, 97);
        check_val("frame_strobe_spacing", bad_gap, 0);
        if (cap.size() >= 97) begin
            for (int k = 0; k < 6; k++) begin
                w = '0;
                for (int i = 0; i < 16; i++) w = {w[14:0], cap[1 + 16*k + i][0]};
                check_val($sformatf("frame_word%0d", k), {16'd0, w}, {16'd0, words[k]});
                check_val($sformatf("frame_chan%0d", k), {31'd0, cap[16*k][1]}, {31'd0, k[0]});
            end
        end

        // Minimum pulse width on the serial clock
        reset_stats(2);
        for (int i = 0; i < 40; i++) step(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        check_val("minpulse_count", strobes, 20);
        check_val("minpulse_spacing", bad_gap, 0);
        check_val("minpulse_width", bad_width, 0);

        // Reset asserted mid-stream while sck is high
        repeat (4) step(1'b1, 1'b1, 1'b1);
        check_val("midrst_pre", {29'd0, bus.sck, bus.sd, bus.ws}, 32'h7);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_async_clear", {28'd0, bus.sck, bus.sd, bus.ws, bus.sck_transition}, 32'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        reset_stats(0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        check_val("midrst_no_strobe", strobes, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_val("midrst_edge1", {31'd0, bus.sck_transition}, 32'h0);
        step(1'b1, 1'b0, 1'b0);
        check_val("midrst_edge2", {31'd0, bus.sck_transition}, 32'h1);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        check_val("midrst_single_strobe", strobes, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_synchronizer.md
# i2s_synchronizer

Front-end clock-domain-crossing block of the I2S input (i2s_in) path. It brings the three asynchronous I2S pins (serial clock, serial data, word select) into the 100 MHz system clock domain through matched multi-flop synchronizer chains. It also emits a one-cycle strobe on each rising edge of the synchronized serial clock. The downstream I2S deserializer samples `sd` and `ws` only when that strobe is high and never uses `sck` as a clock.

## Interface
- `SYNC_STAGES`, default 2: flip-flops per synchronizer chain; legal values are 2 and above, and the value is identical for all three chains.
- `clk` input, 1 bit: system clock (100 MHz nominal); the only clock in the block.
- `rst` input, 1 bit: reset, asynchronous and active-high; clears every flop in the block immediately.
- `_sck` input, 1 bit: raw I2S serial clock pin, asynchronous to `clk` (about 1.25–1.5 MHz).
- `_sd` input, 1 bit: raw I2S serial data pin, asynchronous; changes after the rising edge of `_sck`.
- `_ws` input, 1 bit: raw I2S word select pin, asynchronous; 0 = left, 1 = right.
- `sck` output, 1 bit: synchronized serial clock (last stage of its chain).
- `sck_transition` output, 1 bit: single-cycle pulse marking a 0→1 transition of `sck`.
- `sd` output, 1 bit: synchronized serial data.
- `ws` output, 1 bit: synchronized word select.

## Operation
- Each raw input feeds its own shift chain of `SYNC_STAGES` flops clocked by `clk`. Stage 0 samples the pin, and stage i samples stage i-1.
- `sck`, `sd` and `ws` are driven directly by the last stage of their chain. There is no combinational path from any pin to any output.
- All three chains have equal length, so the relative timing of `_sck`, `_sd` and `_ws` at the pins is preserved at the outputs, to within one `clk` cycle of metastability uncertainty per signal.
- Edge detector:
  - One extra flop `sck_d` holds the previous value of `sck`.
  - `sck_transition = sck & ~sck_d`, formed from registered signals only, so it is glitch-free.
  - Only rising edges produce a strobe; falling edges of `sck` produce nothing.
- The data contract with downstream: in the cycle where `sck_transition` = 1, `sd` and `ws` carry the pin values that were present at the `_sck` rising edge. This holds because the transmitter changes `_sd`/`_ws` at least 2 `clk` cycles after `_sck` rises.
- No filtering, debouncing or glitch rejection is done. Any pin pulse that lasts at least one `clk` period may appear at the output.

## Timing
- Reset (`rst` = 1, asynchronous):
  - All chain flops and `sck_d` go to 0.
  - `sck`, `sd`, `ws` and `sck_transition` are 0 while `rst` is high and in the first cycle after release.
- Latency: a pin level that is stable across clk edge k is visible on its output after edge k+`SYNC_STAGES`-1. With the default of 2, that is 2 `clk` edges from pin change to output, with ±1 cycle of sampling uncertainty.
- `sck_transition`:
  - Goes high in the same cycle `sck` first reads 1.
  - Stays high for exactly 1 cycle.
  - Is low again on the next cycle even if `sck` stays high.
- With default stages, strobe latency is 2–3 `clk` cycles after the `_sck` pin rises.
- Maximum strobe rate is one strobe per 2 `clk` cycles; this requires `_sck` high and low each last at least one `clk` period.
- Reset released while `_sck` is already high: the first synchronized 1 on `sck` produces one `sck_transition` pulse, because `sck_d` resets to 0. Downstream must ignore the first strobe after reset.
- Reset asserted mid-stream: all outputs clear immediately. No strobe is generated until a fresh 0→1 of `sck` is seen after release.

## Test plan
- Reset check: hold `rst` = 1 for 20 cycles with `_sck`/`_sd`/`_ws` toggling -> all four outputs stay 0; after release, outputs follow the pins with 2-cycle latency.
- Latency check: with the pins static, step `_sd` from 0 to 1 just after a clk edge -> `sd` rises exactly 2 clk edges later; repeat the check for `_ws` and `_sck`.
- Strobe check: drive `_sck` with a half-period of 40 clk cycles for 100 periods -> exactly 100 `sck_transition` pulses, each 1 cycle wide, spaced 80 cycles apart, with none on falling edges.
- I2S frame check:
  - Stimulus: a 16-bit-per-channel I2S stream, MSB first, with data changing 2 cycles after each `_sck` rise and `_ws` toggling one bit before the MSB. Left/right word pairs are AAAA/FFFF, 1478/A3B9 and 0001/FFFF.
  - Required response: sampling `sd`/`ws` on `sck_transition` reconstructs every word and every channel assignment exactly.
- Minimum-pulse check: drive `_sck` high and low for 1 clk period each -> one strobe every 2 cycles with no strobe missed.
- Mid-stream reset: assert `rst` while `sck` = 1 -> outputs go to 0 asynchronously; after release, a single strobe appears only at the next 0→1 of `_sck`.
